// File: rtl/rf_sequencer_if.sv
// Bundles the rf_sequencer request and status/control signals.
// The master side issues instructions. The slave side is the sequencer.
interface rf_sequencer_if;
  logic       START;
  logic [9:0] INSTR;
  logic       ENW;
  logic [2:0] WRA;
  logic       ENR0;
  logic       ENR1;
  logic [2:0] RDA0;
  logic [2:0] RDA1;
  logic [1:0] DSEL;
  logic [1:0] ALUOP;
  logic       ALEN;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  modport master (
    output START, INSTR,
    input  ENW, WRA, ENR0, ENR1, RDA0, RDA1, DSEL, ALUOP, ALEN, BUSY, DONE, ERR
  );

  modport slave (
    input  START, INSTR,
    output ENW, WRA, ENR0, ENR1, RDA0, RDA1, DSEL, ALUOP, ALEN, BUSY, DONE, ERR
  );
endinterface

// File: rtl/rf_sequencer.sv
// Register-file instruction sequencer.
// It accepts one instruction from IDLE and walks it through DECODE, an optional
// READ, then WRITE and FIN. It drives the register-file and ALU controls as a
// Moore machine, so the outputs depend only on the state and the captured
// instruction.
// Illegal opcodes go straight from DECODE to FIN. They therefore finish one
// cycle earlier than LOAD/MOV and never touch the register file.
module rf_sequencer (
  input logic           CLKb,
  input logic           RSTb,
  rf_sequencer_if.slave bus
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;

  localparam logic [1:0] DSEL_ALU = 2'b00;
  localparam logic [1:0] DSEL_EXT = 2'b01;
  localparam logic [1:0] DSEL_Q0  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    READ,
    WRITE,
    FIN
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [8:0] ir;
  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       is_alu;
  logic       is_legal;
  logic       unused_instr_bit;

  // Bit 6 of the instruction is reserved, so it is never stored.
  assign unused_instr_bit = bus.INSTR[6];

  assign opcode   = ir[8:6];
  assign rx       = ir[5:3];
  assign ry       = ir[2:0];
  assign is_alu   = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_XOR);
  assign is_legal = is_alu || (opcode == OP_LOAD) || (opcode == OP_MOV);

  // State register and instruction capture. IR only loads when a START is taken in IDLE.
  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && bus.START) begin
        ir <= {bus.INSTR[9:7], bus.INSTR[5:0]};
      end
    end
  end

  // Next-state selection and Moore decode of every control output from state and IR.
  always_comb begin
    state_next = state;
    bus.ENW    = 1'b0;
    bus.WRA    = 3'd0;
    bus.ENR0   = 1'b0;
    bus.ENR1   = 1'b0;
    bus.RDA0   = 3'd0;
    bus.RDA1   = 3'd0;
    bus.DSEL   = DSEL_ALU;
    bus.ALUOP  = ALU_ADD;
    bus.ALEN   = 1'b0;
    bus.BUSY   = 1'b0;
    bus.DONE   = 1'b0;
    bus.ERR    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.START) begin
          state_next = DECODE;
        end
      end

      DECODE: begin
        bus.BUSY = 1'b1;
        if (!is_legal) begin
          state_next = FIN;
        end else if (is_alu) begin
          state_next = READ;
        end else begin
          state_next = WRITE;
        end
      end

      READ: begin
        bus.BUSY   = 1'b1;
        bus.ENR0   = 1'b1;
        bus.ENR1   = 1'b1;
        bus.RDA0   = rx;
        bus.RDA1   = ry;
        bus.ALEN   = 1'b1;
        state_next = WRITE;
      end

      WRITE: begin
        bus.BUSY   = 1'b1;
        bus.ENW    = 1'b1;
        bus.WRA    = rx;
        state_next = FIN;
        case (opcode)
          OP_LOAD: bus.DSEL = DSEL_EXT;
          OP_MOV: begin
            bus.DSEL = DSEL_Q0;
            bus.ENR0 = 1'b1;
            bus.RDA0 = ry;
          end
          OP_ADD:  bus.ALUOP = ALU_ADD;
          OP_SUB:  bus.ALUOP = ALU_SUB;
          OP_XOR:  bus.ALUOP = ALU_XOR;
          default: bus.ENW   = 1'b0;
        endcase
      end

      FIN: begin
        bus.BUSY   = 1'b1;
        bus.DONE   = 1'b1;
        bus.ERR    = !is_legal;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
